// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, character width and parity helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Parity bit a transmitter would send for this character (odd = 1 selects odd parity).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus one delay flop for edge detection.
// All flops reset to the idle (high) line level so reset never looks like a start edge.
module uart_rx_sync (
    input  logic bclk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rx_s_d_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Metastability filter and one-cycle-delayed copy of the synchronised line.
    always_ff @(posedge bclk_i) begin
        if (!rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rx_s_o   = sync_q;
    assign rx_s_d_o = dly_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8-bit UART receiver with receive buffer register and sticky error flags.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | counting to the middle of the start bit to reject glitches
// DATA   | sampling 8 data bits at mid-bit, LSB first
// PARITY | sampling the parity bit and latching the mismatch
// STOP   | sampling the stop bit; buffer/flags update one cycle later
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 bclk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx_data,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] RBR,
    output logic                 rx_status,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);

    logic rx_s;
    logic rx_s_d;

    rx_state_t            state_q;
    logic [TW-1:0]        tick_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_q;
    logic                 par_bad_q;
    logic                 done_q;
    logic [DATA_BITS-1:0] rbr_q;
    logic                 status_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_err_q;
    logic                 rd_clr;

    uart_rx_sync u_sync (
        .bclk_i   (bclk),
        .rst_i    (rst),
        .rx_i     (rx_data),
        .rx_s_o   (rx_s),
        .rx_s_d_o (rx_s_d)
    );

    // A host read only acts when there is unread data.
    assign rd_clr = rx_rd & status_q;

    // Framing FSM plus host-side buffer and flags; a completing frame's set wins over a read clear.
    always_ff @(posedge bclk) begin
        if (!rst) begin
            state_q       <= IDLE;
            tick_q        <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            stop_q        <= 1'b0;
            par_bad_q     <= 1'b0;
            done_q        <= 1'b0;
            rbr_q         <= '0;
            status_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (rd_clr) begin
                status_q      <= 1'b0;
                frame_err_q   <= 1'b0;
                parity_err_q  <= 1'b0;
                overrun_err_q <= 1'b0;
            end

            if (done_q) begin
                if (!status_q || rx_rd) begin
                    rbr_q        <= shift_q;
                    status_q     <= 1'b1;
                    frame_err_q  <= (frame_err_q & ~rd_clr) | ~stop_q;
                    parity_err_q <= (parity_err_q & ~rd_clr) | par_bad_q;
                end else begin
                    overrun_err_q <= 1'b1;
                end
            end

            if (!rx_en) begin
                state_q <= IDLE;
                tick_q  <= '0;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        tick_q <= '0;
                        idx_q  <= '0;
                        if (rx_s_d && !rx_s) begin
                            state_q   <= START;
                            par_bad_q <= 1'b0;
                        end
                    end
                    START: begin
                        if (tick_q == TICK_HALF) begin
                            tick_q  <= '0;
                            idx_q   <= '0;
                            state_q <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tick_q == TICK_FULL) begin
                            tick_q          <= '0;
                            shift_q[idx_q]  <= rx_s;
                            if (idx_q == 3'd7) begin
                                state_q <= PARITY_EN ? PARITY : STOP;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    PARITY: begin
                        if (tick_q == TICK_FULL) begin
                            tick_q    <= '0;
                            par_bad_q <= rx_s ^ parity_bit(shift_q, PARITY_ODD);
                            state_q   <= STOP;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    STOP: begin
                        if (tick_q == TICK_FULL) begin
                            tick_q  <= '0;
                            stop_q  <= rx_s;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign RBR         = rbr_q;
    assign rx_status   = status_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: one 8N1 instance and one even-parity instance, checked
// against a character-level model of the receive buffer and its flags.
module tb_uart_receiver;

    localparam int OS = 4;

    logic bclk = 1'b0;
    logic rst = 1'b0;
    logic rx_en = 1'b0;
    logic rx_rd = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    logic [7:0] rbr_a, rbr_b;
    logic st_a, fe_a, pe_a, oe_a;
    logic st_b, fe_b, pe_b, oe_b;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_rbr [2];
    logic       m_st  [2];
    logic       m_fe  [2];
    logic       m_pe  [2];
    logic       m_oe  [2];

    uart_receiver #(.OVERSAMPLE(OS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .bclk(bclk), .rst(rst), .rx_en(rx_en), .rx_data(rx_a), .rx_rd(rx_rd),
        .RBR(rbr_a), .rx_status(st_a), .frame_err(fe_a), .parity_err(pe_a),
        .overrun_err(oe_a)
    );

    uart_receiver #(.OVERSAMPLE(OS), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .bclk(bclk), .rst(rst), .rx_en(rx_en), .rx_data(rx_b), .rx_rd(rx_rd),
        .RBR(rbr_b), .rx_status(st_b), .frame_err(fe_b), .parity_err(pe_b),
        .overrun_err(oe_b)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int i, input string tag);
        if (i == 0) begin
            check({tag, ".a.rbr"}, rbr_a, m_rbr[0]);
            check({tag, ".a.status"}, {7'd0, st_a}, {7'd0, m_st[0]});
            check({tag, ".a.frame"}, {7'd0, fe_a}, {7'd0, m_fe[0]});
            check({tag, ".a.parity"}, {7'd0, pe_a}, {7'd0, m_pe[0]});
            check({tag, ".a.overrun"}, {7'd0, oe_a}, {7'd0, m_oe[0]});
        end else begin
            check({tag, ".b.rbr"}, rbr_b, m_rbr[1]);
            check({tag, ".b.status"}, {7'd0, st_b}, {7'd0, m_st[1]});
            check({tag, ".b.frame"}, {7'd0, fe_b}, {7'd0, m_fe[1]});
            check({tag, ".b.parity"}, {7'd0, pe_b}, {7'd0, m_pe[1]});
            check({tag, ".b.overrun"}, {7'd0, oe_b}, {7'd0, m_oe[1]});
        end
    endtask

    // Model: one completed character arriving at the host side.
    function automatic void m_frame(input int i, input logic [7:0] b, input logic stop,
                                    input logic pbad);
        if (m_st[i]) begin
            m_oe[i] = 1'b1;
        end else begin
            m_rbr[i] = b;
            m_st[i]  = 1'b1;
            m_fe[i]  = m_fe[i] | ~stop;
            m_pe[i]  = m_pe[i] | pbad;
        end
    endfunction

    function automatic void m_read();
        for (int i = 0; i < 2; i++) begin
            if (m_st[i]) begin
                m_st[i] = 1'b0;
                m_fe[i] = 1'b0;
                m_pe[i] = 1'b0;
                m_oe[i] = 1'b0;
            end
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_rbr[i] = 8'h00;
            m_st[i]  = 1'b0;
            m_fe[i]  = 1'b0;
            m_pe[i]  = 1'b0;
            m_oe[i]  = 1'b0;
        end
    endfunction

    task automatic drive_bit(input int i, input logic v);
        if (i == 0) rx_a = v;
        else rx_b = v;
        repeat (OS) @(negedge bclk);
    endtask

    // Start, 8 data bits LSB first, parity bit on the parity instance, stop; line left at stop level.
    task automatic send(input int i, input logic [7:0] b, input logic pbit, input logic stop);
        drive_bit(i, 1'b0);
        for (int k = 0; k < 8; k++) drive_bit(i, b[k]);
        if (i == 1) drive_bit(i, pbit);
        drive_bit(i, stop);
    endtask

    task automatic idle(input int i, input int n);
        if (i == 0) rx_a = 1'b1;
        else rx_b = 1'b1;
        repeat (n) @(negedge bclk);
    endtask

    task automatic read_pulse();
        rx_rd = 1'b1;
        @(negedge bclk);
        rx_rd = 1'b0;
        m_read();
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        logic       pbit;
        int         i;

        m_reset();
        repeat (3) @(negedge bclk);
        check_inst(0, "reset");
        check_inst(1, "reset");
        rst   = 1'b1;
        rx_en = 1'b1;
        repeat (2 * OS) @(negedge bclk);

        // Basic character with exact completion timing: sync(2) + edge(1) + half bit + load(1)
        // after the start edge, i.e. two cycles past the end of a 4-tick stop bit.
        send(0, 8'h6C, 1'b0, 1'b1);
        @(negedge bclk);
        check("lat_early", {7'd0, st_a}, 8'h00);
        @(negedge bclk);
        check("lat_rise", {7'd0, st_a}, 8'h01);
        m_frame(0, 8'h6C, 1'b1, 1'b0);
        idle(0, 2 * OS);
        check_inst(0, "6C");
        read_pulse();
        check_inst(0, "6C_read");

        // Overrun: second character discarded.
        send(0, 8'h6D, 1'b0, 1'b1);
        idle(0, 2 * OS);
        m_frame(0, 8'h6D, 1'b1, 1'b0);
        send(0, 8'hA5, 1'b0, 1'b1);
        idle(0, 2 * OS);
        m_frame(0, 8'hA5, 1'b1, 1'b0);
        check_inst(0, "overrun");
        read_pulse();
        check_inst(0, "overrun_read");

        // Framing error then a held-low line that must not retrigger.
        send(0, 8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge bclk);
        m_frame(0, 8'h3C, 1'b0, 1'b0);
        check_inst(0, "break");
        idle(0, 2 * OS);
        read_pulse();
        send(0, 8'h01, 1'b0, 1'b1);
        idle(0, 2 * OS);
        m_frame(0, 8'h01, 1'b1, 1'b0);
        check_inst(0, "after_break");

        // Even parity: 8'h07 has three ones, so the correct parity bit is 1.
        send(1, 8'h07, 1'b0, 1'b1);
        idle(1, 2 * OS);
        m_frame(1, 8'h07, 1'b1, 1'b1);
        check_inst(1, "par_bad");
        read_pulse();
        send(1, 8'h07, 1'b1, 1'b1);
        idle(1, 2 * OS);
        m_frame(1, 8'h07, 1'b1, 1'b0);
        check_inst(1, "par_good");
        read_pulse();

        // Quarter-bit low glitch on an idle line.
        rx_a = 1'b0;
        repeat (OS / 4) @(negedge bclk);
        idle(0, 3 * OS);
        check_inst(0, "glitch");

        // Reset in the middle of the data bits.
        send(0, 8'h5A, 1'b0, 1'b1);
        idle(0, 2 * OS);
        m_frame(0, 8'h5A, 1'b1, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        rst  = 1'b0;
        rx_a = 1'b1;
        @(negedge bclk);
        rst = 1'b1;
        m_reset();
        check_inst(0, "mid_rst");
        check_inst(1, "mid_rst");
        idle(0, 2 * OS);
        send(0, 8'hFF, 1'b0, 1'b1);
        idle(0, 2 * OS);
        m_frame(0, 8'hFF, 1'b1, 1'b0);
        check_inst(0, "FF_after_rst");
        read_pulse();

        // Receiver disabled mid-frame: nothing loaded, buffer retained.
        b = 8'h96;
        drive_bit(0, 1'b0);
        drive_bit(0, b[0]);
        rx_en = 1'b0;
        for (int k = 1; k < 8; k++) drive_bit(0, b[k]);
        drive_bit(0, 1'b1);
        idle(0, 2 * OS);
        rx_en = 1'b1;
        idle(0, 2 * OS);
        check_inst(0, "rx_en_drop");

        // Randomised characters on both instances.
        for (int it = 0; it < 16; it++) begin
            i    = int'($urandom_range(0, 1));
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pbit = (^b) ^ ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) read_pulse();
            send(i, b, pbit, stop);
            idle(i, 2 * OS);
            m_frame(i, b, stop, (i == 1) ? (pbit != (^b)) : 1'b0);
            check_inst(i, $sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
